// File: rtl/uart_fifo_param.sv
// Parametrised synchronous byte FIFO between the UART core and the debug/pipeline controller.
// Optional build macro UART_FIFO_OVERWRITE_EN: a write while full drops the oldest entry instead of the new one.
module uart_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_BITS     = 7,
    parameter int AFULL_THRESH  = (1 << ADDR_BITS) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write_flag,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_next,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  empty_flag,
    output logic                  full_flag,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned        DEPTH      = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] LEVEL_FULL = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] LEVEL_AF   = (ADDR_BITS + 1)'(AFULL_THRESH);
    localparam logic [ADDR_BITS:0] LEVEL_AE   = (ADDR_BITS + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]    level_q, level_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic is_empty, is_full, do_read, do_write, drop_oldest;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LEVEL_FULL);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        do_read      = read_next && !is_empty;
        drop_oldest  = 1'b0;
`ifdef UART_FIFO_OVERWRITE_EN
        drop_oldest  = write_flag && is_full && !read_next;
`endif
        // A full FIFO still accepts a write when the same-cycle read frees a slot.
        do_write     = write_flag && (!is_full || do_read || drop_oldest);

        wr_ptr_d     = do_write ? wr_ptr_q + ADDR_BITS'(1) : wr_ptr_q;
        rd_ptr_d     = (do_read || drop_oldest) ? rd_ptr_q + ADDR_BITS'(1) : rd_ptr_q;

        level_d      = level_q;
        if (do_write && !do_read && !drop_oldest) begin
            level_d = level_q + (ADDR_BITS + 1)'(1);
        end else if (do_read && !do_write) begin
            level_d = level_q - (ADDR_BITS + 1)'(1);
        end

        data_out_d   = do_read ? mem[rd_ptr_q] : data_out_q;
        data_valid_d = do_read;
        overflow_d   = overflow_q  || (write_flag && is_full && !read_next);
        underflow_d  = underflow_q || (read_next && is_empty);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (do_write && !reset && !clear) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign level        = level_q;
    assign empty_flag   = is_empty;
    assign full_flag    = is_full;
    assign almost_full  = (level_q >= LEVEL_AF);
    assign almost_empty = (level_q <= LEVEL_AE);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Randomised and directed bench for uart_fifo_param (DEPTH=4) against a queue-based reference model.
module tb_uart_fifo_param;

    localparam int DW    = 8;
    localparam int AB    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clock = 1'b0;
    logic          reset, clear, write_flag, read_next;
    logic [DW-1:0] data_in, data_out;
    logic          data_valid, empty_flag, full_flag, almost_full, almost_empty;
    logic [AB:0]   level;
    logic          overflow, underflow;

    always #5 clock = ~clock;

    uart_fifo_param #(
        .DATA_WIDTH   (DW),
        .ADDR_BITS    (AB),
        .AFULL_THRESH (AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .write_flag  (write_flag),
        .data_in     (data_in),
        .read_next   (read_next),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .empty_flag  (empty_flag),
        .full_flag   (full_flag),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue holding the live entries, oldest first.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_dv, m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit clr, input bit wf,
                              input logic [DW-1:0] d, input bit rn);
        int n;
        if (rst || clr) begin
            mq.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            return;
        end
        n    = mq.size();
        m_dv = rn && (n > 0);
        if (m_dv) m_dout = mq.pop_front();
        if (rn && n == 0) m_unf = 1'b1;
        if (wf) begin
            if (n < DEPTH || m_dv) begin
                mq.push_back(d);
            end else begin
                m_ovf = 1'b1;
`ifdef UART_FIFO_OVERWRITE_EN
                mq.delete(0);
                mq.push_back(d);
`endif
            end
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check("data_valid",   32'(data_valid),   32'(m_dv));
        check("data_out",     32'(data_out),     32'(m_dout));
        check("level",        32'(level),        32'(n));
        check("empty_flag",   32'(empty_flag),   32'(n == 0));
        check("full_flag",    32'(full_flag),    32'(n == DEPTH));
        check("almost_full",  32'(almost_full),  32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_unf));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare 1 time unit later.
    task automatic step(input bit rst, input bit clr, input bit wf,
                        input logic [DW-1:0] d, input bit rn);
        reset      = rst;
        clear      = clr;
        write_flag = wf;
        data_in    = d;
        read_next  = rn;
        @(posedge clock);
        model_step(rst, clr, wf, d, rn);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; write_flag = 1'b0; read_next = 1'b0; data_in = '0;

        // Reset state
        step(1, 0, 0, 8'h00, 0);
        check("rst_empty", 32'(empty_flag), 32'd1);

        // Push three, check almost_full, pop three
        step(0, 0, 1, 8'h11, 0);
        step(0, 0, 1, 8'h22, 0);
        step(0, 0, 1, 8'h33, 0);
        check("lvl3_afull", 32'(almost_full), 32'd1);
        step(0, 0, 0, 8'h00, 1);
        check("pop_11", 32'(data_out), 32'h11);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        check("pop_33", 32'(data_out), 32'h33);
        step(0, 0, 0, 8'h00, 0);

        // Overfill without read, then drain
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'hA0 + 8'(i), 0);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 0);

        // Read on empty with simultaneous write
        step(0, 0, 1, 8'h5A, 1);
        check("unf_lvl1", 32'(level), 32'd1);
        step(0, 0, 0, 8'h00, 1);
        check("pop_5A", 32'(data_out), 32'h5A);
        step(1, 0, 0, 8'h00, 0);

        // Full with simultaneous read/write for 6 cycles
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'hA0 + 8'(i), 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'hB0 + 8'(i), 1);
        check("full_rw_noovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 0);

        // Push/pop pairs across pointer wrap, then clear mid-stream
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 8'(8'hC0 + i), 0);
            step(0, 0, 0, 8'h00, 1);
        end
        step(0, 0, 1, 8'hD1, 0);
        step(0, 0, 1, 8'hD2, 1);
        step(0, 1, 1, 8'hD3, 1);
        check("clr_level", 32'(level), 32'd0);

        // Random traffic with occasional reset/clear
        for (int i = 0; i < 800; i++) begin
            bit rst, clr, wf, rn;
            rst = ($urandom_range(0, 79) == 0);
            clr = ($urandom_range(0, 39) == 0);
            wf  = ($urandom_range(0, 99) < 55);
            rn  = ($urandom_range(0, 99) < 50);
            step(rst, clr, wf, 8'($urandom), rn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
